// File: rtl/bpfvm_pkg.sv
// bpfvm_pkg: definitions shared between the BPF VM scratch memory and the
// blocks that sit beside it.
//   dump_state_t        - state encoding of the scratch dump walker
//   SCRATCH_ADDR_WIDTH  - default scratch address width (16 words)
//   SCRATCH_DATA_WIDTH  - default scratch word width
package bpfvm_pkg;

  localparam int SCRATCH_ADDR_WIDTH = 4;
  localparam int SCRATCH_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SEND = 2'b10
  } dump_state_t;

endpackage : bpfvm_pkg

// File: rtl/scratch_dump.sv
// scratch_dump: walks every scratch word and streams it to the host debug
// path. The scratch read port is borrowed one word per grant (mem_req /
// mem_gnt), so the CPU owning the port is never stalled. Output is a
// valid/ready stream with a last flag on the final index.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        pulse; begins a dump when idle, ignored while busy
//   mem_req      request for the scratch read port (REQ state)
//   mem_gnt      port granted this cycle
//   mem_addr     scratch address (word counter)
//   mem_rdata    scratch word at mem_addr, same-cycle
//   dump_data    registered streamed word
//   dump_addr    scratch index of dump_data
//   dump_valid   dump_data valid
//   dump_ready   consumer accepts on valid & ready
//   dump_last    marks the final index
//   busy         dump in progress
//   done         one-cycle pulse after the last word is accepted
module scratch_dump
  import bpfvm_pkg::*;
#(
  parameter int ADDR_WIDTH = SCRATCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCRATCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};

  dump_state_t           state_r;
  dump_state_t           state_s;
  logic                  mem_req_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] dump_data_r;
  logic [ADDR_WIDTH-1:0] dump_addr_r;
  logic                  dump_valid_r;
  logic                  dump_last_r;
  logic                  done_r;

  assign accept_s = dump_valid_r & dump_ready;

  // Next-state selection and port request, decoded from the current state.
  always_comb begin
    state_s   = state_r;
    mem_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        mem_req_s = 1'b1;
        if (mem_gnt) begin
          state_s = SEND;
        end else begin
          state_s = REQ;
        end
      end
      SEND: begin
        if (accept_s) begin
          // The last word returns to IDLE; otherwise fetch the next word.
          if (dump_last_r) begin
            state_s = IDLE;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, word counter, output stage and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= ADDR_ZERO;
      dump_data_r  <= {DATA_WIDTH{1'b0}};
      dump_addr_r  <= ADDR_ZERO;
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= ADDR_ZERO;
          end
        end
        REQ: begin
          // Snapshot the word on the granted cycle; the port is released
          // immediately afterwards, so later gnt changes cannot affect it.
          if (mem_gnt) begin
            dump_data_r  <= mem_rdata;
            dump_addr_r  <= cnt_r;
            dump_valid_r <= 1'b1;
            dump_last_r  <= (cnt_r == ADDR_MAX);
          end
        end
        SEND: begin
          if (accept_s) begin
            dump_valid_r <= 1'b0;
            if (dump_last_r) begin
              done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + ADDR_ONE;
            end
          end
        end
        default: begin
          dump_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_s;
  assign mem_addr   = cnt_r;
  assign dump_data  = dump_data_r;
  assign dump_addr  = dump_addr_r;
  assign dump_valid = dump_valid_r;
  assign dump_last  = dump_last_r;
  assign busy       = (state_r != IDLE);
  assign done       = done_r;

endmodule : scratch_dump

// File: tb/tb_scratch_dump.sv
// tb_scratch_dump: self-checking bench for scratch_dump. The scratch memory
// lives in the bench; a stream monitor predicts every beat as "next index in
// order, carrying the current scratch contents at that index", and checks
// stability under backpressure and the done pulse.
module tb_scratch_dump;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_req;
  logic          mem_gnt = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic          dump_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NW];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            exp_idx = 0;
  int            beat_cnt = 0;
  bit            acc_last_prev = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;
  logic          hold_last;

  scratch_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dump_data (dump_data),
    .dump_addr (dump_addr),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_last (dump_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for a word: either requested on the port or presented on the stream.
  task automatic wait_word(input bit on_stream, input int idx);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (on_stream ? (dump_valid === 1'b1 && int'(dump_addr) == idx)
                    : (mem_req === 1'b1 && int'(mem_addr) == idx)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_word_reached", ok, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  // Stream monitor: checks each accepted beat against the model sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx       = 0;
      acc_last_prev = 1'b0;
      stall_prev    = 1'b0;
    end else begin
      chk("done_pulse", done, acc_last_prev);
      if (stall_prev) begin
        chk("hold_valid", dump_valid, 1'b1);
        chk("hold_data", dump_data, hold_data);
        chk("hold_addr", dump_addr, hold_addr);
        chk("hold_last", dump_last, hold_last);
      end
      if (mem_req) begin
        chk("req_addr", mem_addr, exp_idx);
        chk("req_no_valid", dump_valid, 1'b0);
      end
      acc_last_prev = 1'b0;
      stall_prev    = 1'b0;
      if (dump_valid) begin
        if (dump_ready) begin
          chk("beat_addr", dump_addr, exp_idx);
          chk("beat_data", dump_data, mem[exp_idx]);
          chk("beat_last", dump_last, (exp_idx == NW - 1));
          beat_cnt++;
          acc_last_prev = (exp_idx == NW - 1);
          exp_idx = acc_last_prev ? 0 : exp_idx + 1;
        end else begin
          stall_prev = 1'b1;
          hold_data  = dump_data;
          hold_addr  = dump_addr;
          hold_last  = dump_last;
        end
      end
    end
  end

  initial begin
    int n;
    int idx;

    for (int i = 0; i < NW; i++) mem[i] = 32'hA000_0000 + i;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", dump_valid, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_last", dump_last, 1'b0);
    chk("rst_data", dump_data, 32'h0);
    chk("rst_daddr", dump_addr, 4'h0);
    chk("rst_maddr", mem_addr, 4'h0);
    rst = 1'b0;
    tick();

    // basic full-speed dump: first valid two cycles after start, done at 32
    mem_gnt    = 1'b1;
    dump_ready = 1'b1;
    beat_cnt   = 0;
    pulse_start();
    chk("lat_busy", busy, 1'b1);
    chk("lat_req", mem_req, 1'b1);
    chk("lat_valid", dump_valid, 1'b0);
    tick();
    chk("lat_first_valid", dump_valid, 1'b1);
    chk("lat_first_addr", dump_addr, 4'h0);
    chk("lat_first_data", dump_data, 32'hA000_0000);
    wait_done(n);
    chk("basic_cycles", n + 1, 32);
    chk("basic_beats", beat_cnt, NW);
    tick();
    chk("basic_done_once", done, 1'b0);
    chk("basic_idle", busy, 1'b0);

    // grant stall, interleaved write, start while busy, backpressure,
    // start coincident with done, restart one cycle after done
    beat_cnt = 0;
    pulse_start();
    wait_word(1'b0, 3);
    mem_gnt = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_req", mem_req, 1'b1);
      chk("stall_addr", mem_addr, 4'd3);
      chk("stall_no_valid", dump_valid, 1'b0);
    end
    mem_gnt = 1'b1;
    wait_word(1'b1, 4);
    mem[9] = 32'hDEAD_BEEF;
    wait_word(1'b1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", busy, 1'b1);
    wait_word(1'b1, 7);
    dump_ready = 1'b0;
    repeat (4) begin
      tick();
      chk("bp_counter", mem_addr, 4'd7);
    end
    dump_ready = 1'b1;
    wait_word(1'b1, 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("coinc_done", done, 1'b1);
    chk("coinc_idle", busy, 1'b0);
    chk("mixed_beats", beat_cnt, NW);
    beat_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    chk("restart_addr", mem_addr, 4'h0);
    wait_done(n);
    chk("restart_beats", beat_cnt, NW);
    tick();

    // reset while word 10 is held in SEND aborts the dump
    pulse_start();
    wait_word(1'b1, 10);
    dump_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", dump_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req", mem_req, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_no_done", done, 1'b0);
    dump_ready = 1'b1;
    beat_cnt = 0;
    pulse_start();
    wait_done(n);
    chk("after_abort_beats", beat_cnt, NW);
    tick();

    // randomized grant/ready patterns with CPU writes to not-yet-dumped words
    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      beat_cnt = 0;
      pulse_start();
      n = 0;
      while (done !== 1'b1 && n < 1000) begin
        mem_gnt    = ($urandom_range(0, 9) < 7);
        dump_ready = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 3) == 0) begin
          idx = int'($urandom_range(0, NW - 1));
          if (idx > exp_idx) mem[idx] = $urandom;
        end
        tick();
        n++;
      end
      chk("rand_done", done, 1'b1);
      chk("rand_beats", beat_cnt, NW);
      mem_gnt    = 1'b1;
      dump_ready = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_scratch_dump
